// File: rtl/dp16ka_pkg.sv
// Shared definitions for the DP16KA dual-port block RAM model.
// Holds the array geometry, the port mode enumerations, and the helpers that
// validate parameters and map a 4-bit sub-word address onto a bit offset
// within an 18-bit row.
package dp16ka_pkg;

  localparam int ROWS   = 1024;
  localparam int ROW_W  = 18;
  localparam int ADDR_W = 14;
  localparam int RADDR_W = 10;

  typedef enum logic [1:0] {
    WM_NORMAL,
    WM_WRITETHROUGH,
    WM_READBEFOREWRITE
  } write_mode_e;

  typedef enum logic {
    RM_NOREG,
    RM_OUTREG
  } reg_mode_e;

  function automatic bit width_legal(int w);
    return (w == 1) || (w == 2) || (w == 4) || (w == 9) || (w == 18);
  endfunction

  function automatic bit write_mode_legal(string s);
    return (s == "NORMAL") || (s == "WRITETHROUGH") || (s == "READBEFOREWRITE");
  endfunction

  function automatic bit reg_mode_legal(string s);
    return (s == "NOREG") || (s == "OUTREG");
  endfunction

  function automatic write_mode_e to_write_mode(string s);
    if (s == "WRITETHROUGH")    return WM_WRITETHROUGH;
    if (s == "READBEFOREWRITE") return WM_READBEFOREWRITE;
    return WM_NORMAL;
  endfunction

  function automatic reg_mode_e to_reg_mode(string s);
    return (s == "OUTREG") ? RM_OUTREG : RM_OUTREG == RM_NOREG ? RM_NOREG : ((s == "OUTREG") ? RM_OUTREG : RM_NOREG);
  endfunction

  // Start bit of a W-wide slice inside an 18-bit row.
  // x18 uses the whole row, x9 picks a half by ad[3]. Narrow widths index the
  // 16 data bits {[16:9],[7:0]} linearly; a linear offset of 8 or more skips
  // the parity bit at position 8. Aligned narrow slices never straddle it.
  function automatic logic [4:0] slice_offset(int w, logic [3:0] ad);
    logic [3:0] lin;
    lin = '0;
    slice_offset = '0;
    case (w)
      18: slice_offset = 5'd0;
      9:  slice_offset = ad[3] ? 5'd9 : 5'd0;
      default: begin
        lin = ad & ~4'(w - 1);
        slice_offset = (lin < 4'd8) ? {1'b0, lin} : {1'b0, lin} + 5'd1;
      end
    endcase
  endfunction

endpackage

// File: rtl/dp16ka_port.sv
// One access port of the DP16KA.
// Decodes the address into a row and a positioned write mask/data for the
// shared array, selects what the output register captures according to the
// write mode, and holds the one- or two-stage output pipeline.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset of output registers
//   di, ad          write data (low DATA_WIDTH bits used), 14-bit address
//   ce, we, cs      clock enable, write enable, chip select
//   rst             synchronous output-register clear (ignores ce/cs)
//   rd_row          current contents of the addressed row (pre-write)
//   row             addressed row
//   wr_en, wr_mask, wr_data   write request into the shared array
//   dout            read data, bits above DATA_WIDTH are zero
module dp16ka_port
  import dp16ka_pkg::*;
#(
  parameter int          DATA_WIDTH = 18,
  parameter string       REGMODE    = "NOREG",
  parameter string       WRITEMODE  = "NORMAL",
  parameter logic [2:0]  CSDECODE   = 3'b000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ROW_W-1:0]     di,
  input  logic [ADDR_W-1:0]    ad,
  input  logic                 ce,
  input  logic                 we,
  input  logic [2:0]           cs,
  input  logic                 rst,
  input  logic [ROW_W-1:0]     rd_row,
  output logic [RADDR_W-1:0]   row,
  output logic                 wr_en,
  output logic [ROW_W-1:0]     wr_mask,
  output logic [ROW_W-1:0]     wr_data,
  output logic [ROW_W-1:0]     dout
);

  localparam write_mode_e     WM     = to_write_mode(WRITEMODE);
  localparam bit              OUTREG = (REGMODE == "OUTREG");
  localparam logic [ROW_W-1:0] ONES  = ROW_W'((1 << DATA_WIDTH) - 1);

  logic             access;
  logic [4:0]       off;
  logic [ROW_W-1:0] rd_word;
  logic [ROW_W-1:0] stage1_d, stage1_q;
  logic [ROW_W-1:0] stage2_d, stage2_q;

  // NOTE: every signal gets a default at the top of always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    access   = ce && (cs == CSDECODE);
    off      = slice_offset(DATA_WIDTH, ad[3:0]);
    row      = ad[ADDR_W-1:4];
    wr_en    = access && we;
    wr_mask  = ONES << off;
    wr_data  = (di & ONES) << off;
    rd_word  = (rd_row >> off) & ONES;
    stage1_d = stage1_q;
    stage2_d = stage2_q;
    if (rst) begin
      stage1_d = '0;
      stage2_d = '0;
    end else if (access) begin
      // A plain read and read-before-write both capture the pre-write row;
      // write-through captures the port's own data; normal writes hold.
      if (!we || (WM == WM_READBEFOREWRITE)) begin
        stage1_d = rd_word;
      end else if (WM == WM_WRITETHROUGH) begin
        stage1_d = di & ONES;
      end
      stage2_d = stage1_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
    end
  end

  assign dout = OUTREG ? stage2_q : stage1_q;

endmodule

// File: rtl/dp16ka.sv
// DP16KA: 1024 x 18 true dual-port block RAM, single clock.
// Each port has its own width (1/2/4/9/18), write mode, output register mode
// and chip-select decode. Both ports share one array; when both write the
// same bits in a cycle port B wins, and a read sees the pre-edge contents.
// Ports (A and B are symmetric):
//   CLK, RSTN       clock, asynchronous active-low reset of output registers
//   DIx[17:0]       write data
//   ADx[13:0]       address, row = ADx[13:4]
//   CEx, WEx        clock enable, write enable
//   CSx[2:0]        chip select, compared against CSDECODE_x
//   RSTx            synchronous output-register clear
//   DOx[17:0]       read data
module dp16ka
  import dp16ka_pkg::*;
#(
  parameter int         DATA_WIDTH_A = 18,
  parameter int         DATA_WIDTH_B = 18,
  parameter string      REGMODE_A    = "NOREG",
  parameter string      REGMODE_B    = "NOREG",
  parameter string      WRITEMODE_A  = "NORMAL",
  parameter string      WRITEMODE_B  = "NORMAL",
  parameter logic [2:0] CSDECODE_A   = 3'b000,
  parameter logic [2:0] CSDECODE_B   = 3'b000
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [17:0] DIA,
  input  logic [17:0] DIB,
  input  logic [13:0] ADA,
  input  logic [13:0] ADB,
  input  logic        CEA,
  input  logic        CEB,
  input  logic        WEA,
  input  logic        WEB,
  input  logic [2:0]  CSA,
  input  logic [2:0]  CSB,
  input  logic        RSTA,
  input  logic        RSTB,
  output logic [17:0] DOA,
  output logic [17:0] DOB
);

  if (!width_legal(DATA_WIDTH_A)) begin : g_bad_width_a
    $error("dp16ka: illegal DATA_WIDTH_A %0d", DATA_WIDTH_A);
  end
  if (!width_legal(DATA_WIDTH_B)) begin : g_bad_width_b
    $error("dp16ka: illegal DATA_WIDTH_B %0d", DATA_WIDTH_B);
  end
  if (!write_mode_legal(WRITEMODE_A) || !write_mode_legal(WRITEMODE_B)) begin : g_bad_wmode
    $error("dp16ka: illegal WRITEMODE");
  end
  if (!reg_mode_legal(REGMODE_A) || !reg_mode_legal(REGMODE_B)) begin : g_bad_rmode
    $error("dp16ka: illegal REGMODE");
  end

  logic [ROW_W-1:0]   mem_q [ROWS];
  logic [RADDR_W-1:0] row_a, row_b;
  logic               wr_en_a, wr_en_b;
  logic [ROW_W-1:0]   mask_a, mask_b, data_a, data_b;
  logic [ROW_W-1:0]   rd_a, rd_b;
  logic [ROW_W-1:0]   merged_a, merged_b, base_b;

  assign rd_a = mem_q[row_a];
  assign rd_b = mem_q[row_b];

  dp16ka_port #(
    .DATA_WIDTH (DATA_WIDTH_A),
    .REGMODE    (REGMODE_A),
    .WRITEMODE  (WRITEMODE_A),
    .CSDECODE   (CSDECODE_A)
  ) u_port_a (
    .clk     (CLK),
    .rst_n   (RSTN),
    .di      (DIA),
    .ad      (ADA),
    .ce      (CEA),
    .we      (WEA),
    .cs      (CSA),
    .rst     (RSTA),
    .rd_row  (rd_a),
    .row     (row_a),
    .wr_en   (wr_en_a),
    .wr_mask (mask_a),
    .wr_data (data_a),
    .dout    (DOA)
  );

  dp16ka_port #(
    .DATA_WIDTH (DATA_WIDTH_B),
    .REGMODE    (REGMODE_B),
    .WRITEMODE  (WRITEMODE_B),
    .CSDECODE   (CSDECODE_B)
  ) u_port_b (
    .clk     (CLK),
    .rst_n   (RSTN),
    .di      (DIB),
    .ad      (ADB),
    .ce      (CEB),
    .we      (WEB),
    .cs      (CSB),
    .rst     (RSTB),
    .rd_row  (rd_b),
    .row     (row_b),
    .wr_en   (wr_en_b),
    .wr_mask (mask_b),
    .wr_data (data_b),
    .dout    (DOB)
  );

  // Same-row writes are folded into one row value: B's bits are laid over
  // A's merged row, so B wins on overlap and both ports' other bits survive.
  always_comb begin
    merged_a = (rd_a & ~mask_a) | (data_a & mask_a);
    base_b   = (wr_en_a && (row_a == row_b)) ? merged_a : rd_b;
    merged_b = (base_b & ~mask_b) | (data_b & mask_b);
  end

  // NOTE: the array has no reset; its power-up contents are undefined and
  // clearing 1024 rows is neither possible in one cycle nor wanted.
  always_ff @(posedge CLK) begin
    if (wr_en_a) mem_q[row_a] <= merged_a;
    if (wr_en_b) mem_q[row_b] <= merged_b;
  end

endmodule

// File: tb/tb_dp16ka.sv
// Directed bench for dp16ka. Four instances share one stimulus stream, all
// with a x18 port A and CSDECODE_A=3'b101, differing in A's write/register
// mode and B's width, so one sequence covers every mode.
//   u_n  : A NORMAL NOREG,          B x18
//   u_wt : A WRITETHROUGH NOREG,    B x9
//   u_rb : A READBEFOREWRITE NOREG, B x4
//   u_or : A NORMAL OUTREG,         B x1
module tb_dp16ka;

  logic        clk;
  logic        rstn;
  logic [17:0] dia, dib;
  logic [13:0] ada, adb;
  logic        cea, ceb, wea, web;
  logic [2:0]  csa, csb;
  logic        rsta, rstb;
  logic [17:0] doa_n, dob_n, doa_wt, dob_wt, doa_rb, dob_rb, doa_or, dob_or;

  int total = 0;
  int bad   = 0;

  dp16ka #(.DATA_WIDTH_B(18), .WRITEMODE_A("NORMAL"), .CSDECODE_A(3'b101)) u_n (
    .CLK(clk), .RSTN(rstn), .DIA(dia), .DIB(dib), .ADA(ada), .ADB(adb),
    .CEA(cea), .CEB(ceb), .WEA(wea), .WEB(web), .CSA(csa), .CSB(csb),
    .RSTA(rsta), .RSTB(rstb), .DOA(doa_n), .DOB(dob_n));

  dp16ka #(.DATA_WIDTH_B(9), .WRITEMODE_A("WRITETHROUGH"), .CSDECODE_A(3'b101)) u_wt (
    .CLK(clk), .RSTN(rstn), .DIA(dia), .DIB(dib), .ADA(ada), .ADB(adb),
    .CEA(cea), .CEB(ceb), .WEA(wea), .WEB(web), .CSA(csa), .CSB(csb),
    .RSTA(rsta), .RSTB(rstb), .DOA(doa_wt), .DOB(dob_wt));

  dp16ka #(.DATA_WIDTH_B(4), .WRITEMODE_A("READBEFOREWRITE"), .CSDECODE_A(3'b101)) u_rb (
    .CLK(clk), .RSTN(rstn), .DIA(dia), .DIB(dib), .ADA(ada), .ADB(adb),
    .CEA(cea), .CEB(ceb), .WEA(wea), .WEB(web), .CSA(csa), .CSB(csb),
    .RSTA(rsta), .RSTB(rstb), .DOA(doa_rb), .DOB(dob_rb));

  dp16ka #(.DATA_WIDTH_B(1), .REGMODE_A("OUTREG"), .CSDECODE_A(3'b101)) u_or (
    .CLK(clk), .RSTN(rstn), .DIA(dia), .DIB(dib), .ADA(ada), .ADB(adb),
    .CEA(cea), .CEB(ceb), .WEA(wea), .WEB(web), .CSA(csa), .CSB(csb),
    .RSTA(rsta), .RSTB(rstb), .DOA(doa_or), .DOB(dob_or));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic ce, input logic we, input logic [13:0] ad, input logic [17:0] di);
    cea = ce; wea = we; ada = ad; dia = di;
  endtask

  task automatic set_b(input logic ce, input logic we, input logic [13:0] ad, input logic [17:0] di);
    ceb = ce; web = we; adb = ad; dib = di;
  endtask

  initial begin
    rstn = 1'b0; rsta = 1'b0; rstb = 1'b0;
    csa = 3'b101; csb = 3'b000;
    set_a(1'b0, 1'b0, 14'h0, 18'h0);
    set_b(1'b0, 1'b0, 14'h0, 18'h0);
    tick(); tick();
    check("reset_doa_n",  doa_n,  18'h0);
    check("reset_dob_n",  dob_n,  18'h0);
    check("reset_doa_or", doa_or, 18'h0);
    check("reset_dob_wt", dob_wt, 18'h0);
    rstn = 1'b1;

    // x18 write on A, read back on B at every B width.
    set_a(1'b1, 1'b1, 14'h0010, 18'h3ABCD); tick();
    set_a(1'b0, 1'b0, 14'h0, 18'h0);
    set_b(1'b1, 1'b0, 14'h0010, 18'h0); tick();
    check("x18_read_b",     dob_n,  18'h3ABCD);
    check("x9_lo_read_b",   dob_wt, 18'h001CD);
    check("x4_slice0_b",    dob_rb, 18'h0000D);
    check("x1_bit0_b",      dob_or, 18'h00001);

    // Mixed widths: new row 1 value, x9 halves and narrow slices past parity.
    set_b(1'b0, 1'b0, 14'h0, 18'h0);
    set_a(1'b1, 1'b1, 14'h0010, 18'h2FF00); tick();
    set_a(1'b0, 1'b0, 14'h0, 18'h0);
    set_b(1'b1, 1'b0, 14'h0010, 18'h0); tick();
    check("x9_lo_0010",  dob_wt, 18'h00100);
    check("x4_s0_0010",  dob_rb, 18'h00000);
    set_b(1'b1, 1'b0, 14'h0018, 18'h0); tick();
    check("x9_hi_0018",  dob_wt, 18'h0017F);
    check("x4_s2_0018",  dob_rb, 18'h0000F);
    check("x1_b9_0018",  dob_or, 18'h00001);
    check("x18_0018",    dob_n,  18'h2FF00);
    set_b(1'b1, 1'b0, 14'h001F, 18'h0); tick();
    check("x4_s3_001F",  dob_rb, 18'h00007);
    check("x1_b16_001F", dob_or, 18'h00000);
    set_b(1'b0, 1'b0, 14'h0, 18'h0);

    // Write modes on A.
    set_a(1'b1, 1'b1, 14'h0020, 18'h00011); tick();
    set_a(1'b1, 1'b0, 14'h0010, 18'h0); tick();
    check("pre_wm_doa_n", doa_n, 18'h2FF00);
    set_a(1'b1, 1'b1, 14'h0020, 18'h00055); tick();
    check("wm_normal_hold",  doa_n,  18'h2FF00);
    check("wm_writethrough", doa_wt, 18'h00055);
    check("wm_readbefore",   doa_rb, 18'h00011);
    set_a(1'b1, 1'b0, 14'h0020, 18'h0); tick();
    check("wm_readback", doa_n, 18'h00055);

    // OUTREG latency and synchronous output reset.
    set_a(1'b1, 1'b1, 14'h0030, 18'h12345); tick();
    set_a(1'b1, 1'b0, 14'h0030, 18'h0); tick();
    check("noreg_1cyc",    doa_n,  18'h12345);
    check("outreg_not_yet", doa_or, 18'h00055);
    tick();
    check("outreg_2cyc",   doa_or, 18'h12345);
    rsta = 1'b1; tick();
    check("rsta_outreg",   doa_or, 18'h0);
    check("rsta_noreg",    doa_n,  18'h0);
    rsta = 1'b0; tick();
    check("rsta_stage2_clr", doa_or, 18'h0);
    check("rsta_release",  doa_n,  18'h12345);
    tick();
    check("outreg_refill", doa_or, 18'h12345);

    // RSTA clears outputs but does not block a write.
    rsta = 1'b1;
    set_a(1'b1, 1'b1, 14'h0040, 18'h0ABCD); tick();
    check("rsta_during_wr", doa_wt, 18'h0);
    rsta = 1'b0;
    set_a(1'b1, 1'b0, 14'h0040, 18'h0); tick();
    check("wr_under_rsta", doa_n, 18'h0ABCD);

    // Chip-select mismatch and clock-enable low.
    csa = 3'b000;
    set_a(1'b1, 1'b1, 14'h0030, 18'h3FFFF); tick();
    check("cs_miss_hold", doa_n, 18'h0ABCD);
    csa = 3'b101;
    set_a(1'b1, 1'b0, 14'h0030, 18'h0); tick();
    check("cs_miss_nowr", doa_n, 18'h12345);
    set_a(1'b0, 1'b0, 14'h0040, 18'h0); tick();
    check("ce_low_hold",  doa_n, 18'h12345);

    // Simultaneous writes to one row: B wins on overlapping bits only.
    set_a(1'b1, 1'b1, 14'h0050, 18'h11111);
    set_b(1'b1, 1'b1, 14'h0050, 18'h22222); tick();
    check("wt_own_data", doa_wt, 18'h11111);
    set_b(1'b0, 1'b0, 14'h0, 18'h0);
    set_a(1'b1, 1'b0, 14'h0050, 18'h0); tick();
    check("collide_x18", doa_n,  18'h22222);
    check("collide_x9",  doa_wt, 18'h11022);
    check("collide_x4",  doa_rb, 18'h11112);

    // A reads the row B writes in the same cycle: old contents.
    set_b(1'b1, 1'b1, 14'h0050, 18'h33333); tick();
    check("rd_during_b_wr", doa_n, 18'h22222);
    set_b(1'b0, 1'b0, 14'h0, 18'h0); tick();
    check("after_b_wr", doa_n, 18'h33333);

    // Asynchronous reset mid-run: outputs clear at once, array survives.
    #2 rstn = 1'b0;
    #1;
    check("rstn_doa_n",  doa_n,  18'h0);
    check("rstn_dob_n",  dob_n,  18'h0);
    check("rstn_doa_or", doa_or, 18'h0);
    #2 rstn = 1'b1;
    tick();
    check("rstn_data_kept", doa_n, 18'h33333);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
